// File: rtl/fc_layer_sequencer_if.sv
// Result stream from the layer sequencer to the activation stage.
// A transfer happens on a rising edge where out_valid && out_ready; while out_valid is high
// and out_ready is low the master holds out_data and out_index unchanged.
interface fc_layer_sequencer_if #(
  parameter int N  = 32,
  parameter int IW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [IW-1:0] out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed fully connected layer controller: streams input/weight words into one
// shared external fma, folds the bias in as a final fma step and emits one result per neuron.
module fc_layer_sequencer #(
  parameter int input_size  = 32,
  parameter int num_outputs = 10,
  parameter int Q           = 15,
  parameter int N           = 32,
  localparam int IA = (input_size > 1) ? $clog2(input_size) : 1,
  localparam int WA = (input_size * num_outputs > 1) ? $clog2(input_size * num_outputs) : 1,
  localparam int BA = (num_outputs > 1) ? $clog2(num_outputs) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          in_rd_en,
  output logic [IA-1:0] in_addr,
  input  logic [N-1:0]  in_rdata,
  output logic          w_rd_en,
  output logic [WA-1:0] w_addr,
  input  logic [N-1:0]  w_rdata,
  output logic          bias_rd_en,
  output logic [BA-1:0] bias_addr,
  input  logic [N-1:0]  bias_rdata,
  output logic [N-1:0]  fma_a,
  output logic [N-1:0]  fma_b,
  output logic [N-1:0]  fma_c,
  input  logic [N-1:0]  fma_result,
  output logic [2:0]    dbg_state,
  fc_layer_sequencer_if.master out_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_BIAS   = 3'd3,
    S_OUT    = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1} << Q;
  localparam logic [IA-1:0] K_LAST = IA'(input_size - 1);
  localparam logic [BA-1:0] J_LAST = BA'(num_outputs - 1);

  state_e        state_q, state_d;
  logic [IA-1:0] k_q, k_d;
  logic [BA-1:0] j_q, j_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  bias_q, bias_d;
  logic          k_valid_q, k_valid_d;
  logic          bias_valid_q, bias_valid_d;

  logic          out_valid_s;
  logic [N-1:0]  out_data_s;
  logic [BA-1:0] out_index_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      j_q          <= '0;
      acc_q        <= '0;
      bias_q       <= '0;
      k_valid_q    <= 1'b0;
      bias_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      j_q          <= j_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      k_valid_q    <= k_valid_d;
      bias_valid_q <= bias_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    k_valid_d    = 1'b0;
    bias_valid_d = 1'b0;
    in_rd_en     = 1'b0;
    in_addr      = '0;
    w_rd_en      = 1'b0;
    w_addr       = '0;
    bias_rd_en   = 1'b0;
    bias_addr    = '0;
    fma_a        = '0;
    fma_b        = '0;
    fma_c        = '0;
    done         = 1'b0;
    out_valid_s  = 1'b0;
    out_data_s   = '0;
    out_index_s  = '0;

    // Read data lags the strobe by one cycle, so products land one cycle behind k.
    if (k_valid_q) begin
      fma_a = acc_q;
      fma_b = w_rdata;
      fma_c = in_rdata;
      acc_d = fma_result;
    end
    if (bias_valid_q) begin
      bias_d = bias_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        in_rd_en  = 1'b1;
        in_addr   = k_q;
        w_rd_en   = 1'b1;
        w_addr    = WA'(j_q) * WA'(input_size) + WA'(k_q);
        k_valid_d = 1'b1;
        if (k_q == '0) begin
          bias_rd_en   = 1'b1;
          bias_addr    = j_q;
          bias_valid_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_BIAS;
      end
      S_BIAS: begin
        // Bias is added as acc + bias*1.0 through the same fma.
        fma_a   = acc_q;
        fma_b   = bias_q;
        fma_c   = ONE;
        acc_d   = fma_result;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid_s = 1'b1;
        out_data_s  = acc_q;
        out_index_s = j_q;
        if (out_if.out_ready) begin
          if (j_q < J_LAST) begin
            j_d     = j_q + 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy             = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign dbg_state        = state_q;
  assign out_if.out_valid = out_valid_s;
  assign out_if.out_data  = out_data_s;
  assign out_if.out_index = out_index_s;

endmodule
